// File: rtl/jk_ff_bank.sv
// Bank of WIDTH flip-flops acting per-bit as JK, SR, D-load or an up/down toggle-chain counter.
// Latency: one clk edge from sampled inputs to q; tc is combinational from the current inputs and q.
// No backpressure: en=0 freezes q, and clr_illegal still clears the sticky flag while disabled.
module jk_ff_bank #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_illegal,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             illegal,
    output logic             tc
);

    localparam logic [1:0] MODE_JK  = 2'b00;
    localparam logic [1:0] MODE_SR  = 2'b01;
    localparam logic [1:0] MODE_D   = 2'b10;
    localparam logic [1:0] MODE_CNT = 2'b11;

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic             sr_conflict;
    logic             all_ones;
    logic             all_zeros;

    // Toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
    assign t_up[0] = 1'b1;
    assign t_dn[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign t_up[i] = t_up[i-1] & q[i-1];
        assign t_dn[i] = t_dn[i-1] & ~q[i-1];
    end

    assign all_ones  = t_up[WIDTH-1] & q[WIDTH-1];
    assign all_zeros = t_dn[WIDTH-1] & ~q[WIDTH-1];

    always_comb begin
        q_nxt       = q;
        sr_conflict = 1'b0;
        case (mode)
            MODE_JK: q_nxt = (j & ~q) | (~k & q);
            MODE_SR: begin
                // S=R=1 holds the bit; only S/R disagreement forces a value.
                q_nxt       = (j & ~k) | (q & ~(j ^ k));
                sr_conflict = |(j & k);
            end
            MODE_D:  q_nxt = j;
            MODE_CNT: begin
                if (j[0]) begin
                    q_nxt = k[0] ? (q ^ t_dn) : (q ^ t_up);
                end
            end
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RESET_VAL;
            illegal <= 1'b0;
        end else begin
            if (en) begin
                q <= q_nxt;
            end
            if (en && sr_conflict) begin
                illegal <= 1'b1;
            end else if (clr_illegal) begin
                illegal <= 1'b0;
            end
        end
    end

    assign qbar = ~q;
    assign tc   = (mode == MODE_CNT) && en && j[0] && (k[0] ? all_zeros : all_ones);

endmodule

// File: doc/jk_ff_bank.md
Name: jk_ff_bank

Overview:
- Parametrised bank of WIDTH edge-triggered flip-flops with runtime-selectable mode: per-bit JK, per-bit SR, D-load, or up/down counter built from toggle stages.
- Replaces single-bit JK/SR flip-flops in register and counter datapaths.
- Adds bank enable, a sticky SR illegal-input flag and a counter terminal-count output.

Parameters:
- WIDTH, 8, number of flip-flops in the bank (>=2).
- RESET_VAL, 0, WIDTH-bit value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  bank enable; 0 holds all state.
- mode  input  2  00=JK, 01=SR, 10=D, 11=COUNT.
- j  input  WIDTH  J (JK), S (SR), D data (D); bit0=count enable in COUNT.
- k  input  WIDTH  K (JK), R (SR); ignored in D; bit0=direction (0 up, 1 down) in COUNT.
- clr_illegal  input  1  clears sticky illegal flag.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  bitwise complement of q.
- illegal  output  1  sticky flag: SR mode saw S=R=1 on some bit while enabled.
- tc  output  1  terminal count, combinational.

Behaviour:
- Reset: rst=1 at a rising edge sets q=RESET_VAL and illegal=0, overriding en, mode and clr_illegal. qbar=~RESET_VAL and tc follows its combinational definition. Reset mid-count discards the count.
- qbar is continuously ~q, never a separate register. It never disagrees with q.
- en=0: q holds. illegal is still cleared by clr_illegal.
- Latency: one edge. Inputs sampled at edge N appear on q after edge N.
- JK (00), per bit i:
  - j=0,k=0: hold.
  - j=0,k=1: q=0.
  - j=1,k=0: q=1.
  - j=1,k=1: q=~q.
- SR (01), per bit i:
  - s=0,r=0: hold.
  - s=0,r=1: q=0.
  - s=1,r=0: q=1.
  - s=1,r=1: bit holds; illegal set to 1 at that edge.
- D (10): q=j. k is ignored.
- COUNT (11):
  - j[0]=0: q holds.
  - j[0]=1, k[0]=0: q=q+1 mod 2^WIDTH.
  - j[0]=1, k[0]=1: q=q-1 mod 2^WIDTH.
  - Wrap-around is silent: all-ones+1 gives 0, and 0-1 gives all-ones.
  - Implemented as a synchronous T-flip-flop chain. Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  - j[WIDTH-1:1] and k[WIDTH-1:1] are ignored.
- tc = 1 when mode=11, en=1, j[0]=1 and q is about to wrap: q=all-ones with k[0]=0, or q=0 with k[0]=1. Otherwise tc=0.
- illegal:
  - Cleared on an edge with clr_illegal=1.
  - If a new SR 1/1 condition occurs in the same cycle as clr_illegal, set wins and illegal=1.
  - Unaffected by other modes.
- Mode changes take effect at the next edge with no state loss. q carries over between modes unchanged.
- No X propagation from ignored inputs: an X on an ignored bit must not corrupt q.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, rst=1 for one edge with mode=11, en=1, j[0]=1 -> q=A5, qbar=5A, illegal=0. Then rst=1 with clr_illegal=0 after illegal=1 -> illegal=0.
- JK: q=8'h0F, mode=00, en=1, j=8'h33, k=8'h55 -> q=8'h3A after one edge. Repeat with en=0 -> q stays 3A.
- SR illegal: q=8'h00, mode=01, j=8'h81, k=8'h01 -> q=8'h80, illegal=1. Next cycle clr_illegal=1 with j=k=0 -> illegal=0. clr_illegal=1 with j[3]=k[3]=1 -> illegal stays 1.
- D: mode=10, j=8'hC3, k=8'hFF -> q=8'hC3, qbar=8'h3C.
- Count up with wrap: q=8'hFE, mode=11, j[0]=1, k[0]=0:
  - FE: tc=0.
  - Next edge: q=FF, tc=1.
  - Next edge: q=00, tc=0.
- Count down with wrap: starting at 00 with k[0]=1 -> tc=1 before the edge, q=FF after it. Then j[0]=0 -> q holds FF. Then rst asserted mid-count -> q=RESET_VAL.
